// File: rtl/mor1k_wb_pkg.sv
// Shared definitions for the mor1kx Wishbone bus arbiter: cycle-type codes,
// arbiter state encoding and a constant-foldable ceil(log2) helper.
package mor1k_wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mor1k_rr_arbiter.sv
// Combinational one-hot arbiter: round-robin starting after the last winner,
// or fixed priority (lowest index first) when fixed_mode is set.
module mor1k_rr_arbiter #(
    parameter int M_NUM = 2,
    parameter int IW    = 1
) (
    input  logic [M_NUM-1:0] req,
    input  logic [IW-1:0]    last,
    input  logic             fixed_mode,
    output logic [M_NUM-1:0] grant
);

    int   start_idx;
    int   cand_idx;
    logic found;

    // Walk the candidates in priority order; the first requester found wins.
    always_comb begin
        grant     = '0;
        found     = 1'b0;
        cand_idx  = 0;
        start_idx = fixed_mode ? 0 : (int'(last) + 1) % M_NUM;
        for (int i = 0; i < M_NUM; i++) begin
            cand_idx = (start_idx + i) % M_NUM;
            for (int k = 0; k < M_NUM; k++) begin
                if (!found && (k == cand_idx) && req[k]) begin
                    grant[k] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mor1k_wb_bus_arbiter.sv
// Wishbone B3 multi-master to single-slave arbiter with registered grant,
// CPU-enable gate and a bus-timeout watchdog that forces err on hung cycles.
module mor1k_wb_bus_arbiter
    import mor1k_wb_pkg::*;
#(
    parameter int M_NUM      = 2,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int ADDR_SHIFT = 2,
    parameter     ARB_MODE   = "RR",
    parameter int TIMEOUT    = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en_i,
    input  logic [M_NUM*AW-1:0]       m_adr_i,
    input  logic [M_NUM*DW-1:0]       m_dat_i,
    input  logic [M_NUM*(DW/8)-1:0]   m_sel_i,
    input  logic [M_NUM-1:0]          m_we_i,
    input  logic [M_NUM-1:0]          m_cyc_i,
    input  logic [M_NUM-1:0]          m_stb_i,
    input  logic [M_NUM*3-1:0]        m_cti_i,
    input  logic [M_NUM*2-1:0]        m_bte_i,
    output logic [DW-1:0]             m_dat_o,
    output logic [M_NUM-1:0]          m_ack_o,
    output logic [M_NUM-1:0]          m_err_o,
    output logic [M_NUM-1:0]          m_rty_o,
    output logic [AW-1:0]             s_adr_o,
    output logic [DW-1:0]             s_dat_o,
    output logic [(DW/8)-1:0]         s_sel_o,
    output logic                      s_we_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic [2:0]                s_cti_o,
    output logic [1:0]                s_bte_o,
    input  logic [DW-1:0]             s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic                      s_rty_i,
    output logic [M_NUM-1:0]          grant_o,
    output logic                      timeout_o
);

    localparam int SELW       = DW / 8;
    localparam int IW         = (M_NUM > 1) ? clog2(M_NUM) : 1;
    localparam int WDW        = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam bit FIXED_MODE = (ARB_MODE == "FIXED");

    arb_state_t         state_reg, state_next;
    logic [M_NUM-1:0]   grant_reg, grant_next;
    logic [IW-1:0]      last_reg, last_next;
    logic [WDW-1:0]     wd_cnt_reg, wd_cnt_next;
    logic               timeout_reg, timeout_next;

    logic [M_NUM-1:0]   arb_grant;
    logic [IW-1:0]      win_idx;
    logic               granted_cyc;
    logic               granted_stb;
    logic               term;

    logic [M_NUM-1:0][AW-1:0]   adr_mask;
    logic [M_NUM-1:0][DW-1:0]   dat_mask;
    logic [M_NUM-1:0][SELW-1:0] sel_mask;
    logic [M_NUM-1:0][2:0]      cti_mask;
    logic [M_NUM-1:0][1:0]      bte_mask;
    logic [AW-1:0]              adr_sel;

    mor1k_rr_arbiter #(
        .M_NUM (M_NUM),
        .IW    (IW)
    ) u_arb (
        .req        (m_cyc_i),
        .last       (last_reg),
        .fixed_mode (FIXED_MODE),
        .grant      (arb_grant)
    );

    always_comb begin
        win_idx = '0;
        for (int k = 0; k < M_NUM; k++) begin
            if (arb_grant[k]) begin
                win_idx = IW'(k);
            end
        end
    end

    assign granted_cyc = |(grant_reg & m_cyc_i);
    assign granted_stb = |(grant_reg & m_stb_i);
    assign term        = s_ack_i | s_err_i | s_rty_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= '0;
            last_reg    <= IW'(M_NUM - 1);
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            last_reg    <= last_next;
            wd_cnt_reg  <= wd_cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    // Arbitration happens only in IDLE, so a granted burst is never split.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        case (state_reg)
            ST_IDLE: begin
                grant_next = '0;
                if (en_i && |m_cyc_i) begin
                    grant_next = arb_grant;
                    last_next  = win_idx;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!granted_cyc) begin
                    grant_next = '0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < M_NUM; gi++) begin : g_master
            assign adr_mask[gi] = m_adr_i[gi*AW +: AW]     & {AW{grant_reg[gi]}};
            assign dat_mask[gi] = m_dat_i[gi*DW +: DW]     & {DW{grant_reg[gi]}};
            assign sel_mask[gi] = m_sel_i[gi*SELW +: SELW] & {SELW{grant_reg[gi]}};
            assign cti_mask[gi] = m_cti_i[gi*3 +: 3]       & {3{grant_reg[gi]}};
            assign bte_mask[gi] = m_bte_i[gi*2 +: 2]       & {2{grant_reg[gi]}};

            // The forced-err cycle suppresses any late ack/rty from the slave.
            assign m_ack_o[gi] = grant_reg[gi] & s_ack_i & ~timeout_reg;
            assign m_err_o[gi] = grant_reg[gi] & (s_err_i | timeout_reg);
            assign m_rty_o[gi] = grant_reg[gi] & s_rty_i & ~timeout_reg;
        end
    endgenerate

    always_comb begin
        adr_sel = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_cti_o = '0;
        s_bte_o = '0;
        for (int k = 0; k < M_NUM; k++) begin
            adr_sel = adr_sel | adr_mask[k];
            s_dat_o = s_dat_o | dat_mask[k];
            s_sel_o = s_sel_o | sel_mask[k];
            s_cti_o = s_cti_o | cti_mask[k];
            s_bte_o = s_bte_o | bte_mask[k];
        end
    end

    assign s_adr_o   = adr_sel >> ADDR_SHIFT;
    assign s_we_o    = |(grant_reg & m_we_i);
    assign s_cyc_o   = granted_cyc & ~timeout_reg;
    assign s_stb_o   = granted_stb & ~timeout_reg;
    assign m_dat_o   = s_dat_i;
    assign grant_o   = grant_reg;
    assign timeout_o = timeout_reg;

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
            localparam logic [WDW-1:0] WD_MAX  = '1;

            always_comb begin
                wd_cnt_next  = wd_cnt_reg;
                timeout_next = 1'b0;
                if ((state_reg != ST_BUSY) || term || timeout_reg) begin
                    wd_cnt_next = '0;
                end else if (s_stb_o) begin
                    if (wd_cnt_reg == WD_LAST) begin
                        timeout_next = 1'b1;
                        wd_cnt_next  = '0;
                    end else if (wd_cnt_reg != WD_MAX) begin
                        wd_cnt_next = wd_cnt_reg + WDW'(1);
                    end
                end
            end
        end else begin : g_no_wd
            assign wd_cnt_next  = '0;
            assign timeout_next = 1'b0;
        end
    endgenerate

endmodule

// File: doc/mor1k_wb_bus_arbiter.md
Name: mor1k_wb_bus_arbiter

Overview:
Parametrised Wishbone B3 multi-master arbiter with a single slave port. It merges M_NUM CPU bus masters (e.g. mor1kx instruction and data buses, or several cores) onto one slave port. Master byte addresses are converted to word addresses using a configurable shift. The block adds round-robin or fixed-priority arbitration, a CPU-enable grant gate, and a bus-timeout watchdog that terminates hung cycles with err.

Parameters:
M_NUM, 2, number of masters (1..8)
AW, 32, address width
DW, 32, data width; SELW = DW/8
ADDR_SHIFT, 2, number of low address bits dropped (0 = byte address passthrough)
ARB_MODE, "RR", "RR" round-robin or "FIXED" (lowest index wins)
TIMEOUT, 255, cycles without termination before forced err; 0 disables the watchdog

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en_i  in  1  when low, no new grant is issued; the current grant is held
m_adr_i  in  M_NUM*AW  master addresses (byte), master k at [k*AW +: AW]
m_dat_i  in  M_NUM*DW  master write data
m_sel_i  in  M_NUM*SELW  byte selects
m_we_i  in  M_NUM  write enables
m_cyc_i  in  M_NUM  cycle requests
m_stb_i  in  M_NUM  strobes
m_cti_i  in  M_NUM*3  cycle type identifiers
m_bte_i  in  M_NUM*2  burst type extensions
m_dat_o  out  DW  read data, broadcast to all masters
m_ack_o  out  M_NUM  ack, asserted only to the granted master
m_err_o  out  M_NUM  err, asserted only to the granted master (includes timeout)
m_rty_o  out  M_NUM  rty, asserted only to the granted master
s_adr_o  out  AW  slave address = {ADDR_SHIFT zeros, adr[AW-1:ADDR_SHIFT]}
s_dat_o  out  DW  slave write data
s_sel_o  out  SELW  slave byte selects
s_we_o  out  1  slave write enable
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_cti_o  out  3  slave cycle type
s_bte_o  out  2  slave burst type
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave err
s_rty_i  in  1  slave rty
grant_o  out  M_NUM  one-hot registered grant
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (async, rst_n=0):
  - grant_o=0, state IDLE, RR pointer last=M_NUM-1, watchdog count=0, timeout_o=0.
  - All s_* outputs are 0; all m_ack/err/rty are 0.
- State machine: IDLE, BUSY.
  - IDLE, en_i=1, any m_cyc_i high: winner is chosen combinationally and registered into grant_o; go to BUSY.
  - Arbitration latency is 1 cycle: the winner's cyc appears on s_cyc_o in the cycle after the request is sampled.
  - IDLE, en_i=0: stay in IDLE; grant_o=0.
  - BUSY: grant is held while the granted m_cyc_i=1. This covers burst lock: cti 001/010 is never interrupted.
  - BUSY, granted m_cyc_i=0: grant_o clears at the next edge; go to IDLE. Re-arbitration occurs in that IDLE cycle.
  - en_i going low in BUSY does not abort the current cycle.
- RR selection: search starts at index last+1 modulo M_NUM; last is updated to the winner on grant. FIXED: lowest index wins.
- Muxing:
  - s_* outputs come from the granted master; they are all zero when no grant.
  - s_dat_i is broadcast to m_dat_o unconditionally.
  - ack/err/rty are ANDed with grant_o bit k.
- Watchdog (TIMEOUT>0):
  - Counts cycles in BUSY with s_stb_o=1 and none of ack/err/rty.
  - Clears on any termination, and on leaving BUSY.
  - When count==TIMEOUT-1 and no termination: next cycle m_err_o[granted]=1 for one cycle, timeout_o=1, s_cyc_o/s_stb_o forced 0 that cycle, count reset.
  - A real s_ack_i arriving in the same cycle as expiry wins; no timeout fires.
  - The counter width is clog2(TIMEOUT+1); it saturates rather than wraps.
- Simultaneous requests: exactly one grant per arbitration, and grant_o is always one-hot or zero.
- s_ack_i while no grant is ignored.
- M_NUM=1 degenerates to a pass-through with 1-cycle grant latency plus the watchdog.

Decomposition:
- Package mor1k_wb_pkg: CTI constants (CLASSIC=000, CONST=001, INCR=010, EOB=111), state encoding, and the clog2 function.
- Sub-module mor1k_rr_arbiter (request vector, last pointer, mode in; one-hot grant out), purely combinational.
- The top level holds the FSM, grant register, muxes, and watchdog.

Test Plan:
- Single master 0 read, adr=0x0000_1004, ADDR_SHIFT=2 -> s_adr_o=0x0000_0401 one cycle after cyc; slave ack with 0xDEADBEEF -> m_dat_o=0xDEADBEEF, m_ack_o=01.
- Both masters request every cycle, RR, 3 transactions each -> grants alternate 0,1,0,1,0,1 with one IDLE cycle between grants; FIXED mode -> master 0 takes all of its transactions first.
- Master 1 runs a 4-beat INCR burst (cti 010,010,010,111) while master 0 requests -> grant_o stays 10 until master 1 drops cyc, then becomes 01.
- TIMEOUT=8, slave never acks -> err pulse to the granted master 8 cycles after stb, timeout_o=1, s_cyc_o=0 that cycle; a variant with ack on the 8th cycle -> ack only, no err.
- en_i=0 with requests pending -> grant_o stays 0; en_i raised -> grant in the next cycle. en_i dropped mid-BUSY -> the current transaction completes normally.
- rst_n asserted mid-burst -> all outputs 0 immediately (asynchronous); after release the RR pointer is at master 0 first.
